// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the MEM-stage bus controller: FSM states, UART
// register addresses and the layout of the UART status word.
package mem_bus_ctrl_pkg;

    localparam logic [15:0] UART_DATA_ADDR_DFLT = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR_DFLT = 16'hBF01;
    localparam logic [1:0]  RAM_ADDR_HI_DFLT    = 2'b00;

    localparam int STAT_DATA_READY_BIT = 1;
    localparam int STAT_TX_EMPTY_BIT   = 0;

    typedef enum logic [3:0] {
        IDLE, SRD, SWR1, SWR2, URW, UR1, UR2, UW1, UW2, UWT, UWS, DONE
    } state_e;

    function automatic logic [15:0] status_word(input logic data_ready, input logic tx_empty);
        logic [15:0] w;
        w = '0;
        w[STAT_DATA_READY_BIT] = data_ready;
        w[STAT_TX_EMPTY_BIT]   = tx_empty;
        return w;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_bus_tristate.sv
// 16-bit tri-state driver for the shared RAM1/UART bus, with a read-data
// register that either captures the bus (full word or low byte) or loads a word.
module bus_tristate (
    input  logic        clk,
    input  logic        rst,
    input  logic        oe_i,
    input  logic [15:0] dout_i,
    input  logic        cap_en_i,
    input  logic        cap_byte_i,
    input  logic        load_en_i,
    input  logic [15:0] load_val_i,
    inout  wire  [15:0] bus_io,
    output logic [15:0] sample_o
);

    logic [15:0] sample_q;

    assign bus_io = oe_i ? dout_i : 'z;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sample_q <= '0;
        end else if (load_en_i) begin
            sample_q <= load_val_i;
        end else if (cap_en_i) begin
            sample_q <= cap_byte_i ? {8'h00, bus_io[7:0]} : bus_io;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage responder: runs multi-cycle RAM1 SRAM and UART bus cycles on a
// shared 16-bit data bus and stalls the pipeline until each access completes.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DFLT,
    parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DFLT,
    parameter logic [1:0]  RAM_ADDR_HI    = RAM_ADDR_HI_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [17:0] ram1_addr_o,
    inout  wire  [15:0] ram1_data_io,
    output logic        ram1_en_o,
    output logic        ram1_oe_o,
    output logic        ram1_we_o,
    output logic        rdn_o,
    output logic        wrn_o,
    input  logic        data_ready_i,
    input  logic        tbre_i,
    input  logic        tsre_i,
    output state_e      state_o
);

    state_e      state_q;
    logic        en_q, oe_q, we_q, rdn_q, wrn_q, drive_q, done_q;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;
    logic        req, is_data, is_stat;
    logic        cap_en, cap_byte, load_en;

    // Handshake: a request is memread_i XOR memwrite_i; the requester holds its
    // inputs while stall_o=1 and advances on the edge that ends the done_o cycle.
    assign req     = memread_i ^ memwrite_i;
    assign is_data = (addr_i == UART_DATA_ADDR);
    assign is_stat = (addr_i == UART_STAT_ADDR);
    assign stall_o = req && (state_q != DONE);

    assign cap_en   = (state_q == SRD) || (state_q == UR2);
    assign cap_byte = (state_q == UR2);
    assign load_en  = (state_q == IDLE) && req && is_stat && memread_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            en_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (req) begin
                    wdata_q <= wdata_i;
                    if (is_stat) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (is_data) begin
                        if (memread_i) begin
                            state_q <= URW;
                        end else begin
                            state_q <= UW1;
                            drive_q <= 1'b1;
                            wrn_q   <= 1'b0;
                        end
                    end else begin
                        addr_q <= {RAM_ADDR_HI, addr_i};
                        en_q   <= 1'b0;
                        if (memread_i) begin
                            state_q <= SRD;
                            oe_q    <= 1'b0;
                        end else begin
                            state_q <= SWR1;
                            we_q    <= 1'b0;
                            drive_q <= 1'b1;
                        end
                    end
                end
                SRD: begin
                    en_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                SWR1: begin
                    we_q    <= 1'b1;
                    state_q <= SWR2;
                end
                SWR2: begin
                    drive_q <= 1'b0;
                    en_q    <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                URW: if (data_ready_i) state_q <= UR1;
                // rdn is low for exactly the UR2 cycle; the byte is captured as it rises.
                UR1: begin
                    rdn_q   <= 1'b0;
                    state_q <= UR2;
                end
                UR2: begin
                    rdn_q   <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                UW1: begin
                    wrn_q   <= 1'b1;
                    state_q <= UW2;
                end
                UW2: begin
                    drive_q <= 1'b0;
                    state_q <= UWT;
                end
                UWT: if (tbre_i) state_q <= UWS;
                UWS: if (tsre_i) begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    bus_tristate u_bus (
        .clk        (clk),
        .rst        (rst),
        .oe_i       (drive_q),
        .dout_i     (wdata_q),
        .cap_en_i   (cap_en),
        .cap_byte_i (cap_byte),
        .load_en_i  (load_en),
        .load_val_i (status_word(data_ready_i, tbre_i & tsre_i)),
        .bus_io     (ram1_data_io),
        .sample_o   (rdata_o)
    );

    assign done_o      = done_q;
    assign ram1_addr_o = addr_q;
    assign ram1_en_o   = en_q;
    assign ram1_oe_o   = oe_q;
    assign ram1_we_o   = we_q;
    assign rdn_o       = rdn_q;
    assign wrn_o       = wrn_q;
    assign state_o     = state_q;

endmodule
